// File: rtl/vx_cache_req_arb_if.sv
// Request-lane bundle for vx_cache_req_arb: N request lanes in, one merged request out.
// master = lane/downstream side (drives requests, consumes merged port); slave = arbiter.
interface vx_cache_req_arb_if #(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int DATA_SIZE     = DATA_WIDTH / 8,
  parameter int LOG_NUM_REQS  = $clog2(NUM_REQS),
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
);
  logic [NUM_REQS-1:0]              req_in_valid;
  logic [NUM_REQS-1:0]              req_in_rw;
  logic [NUM_REQS*DATA_SIZE-1:0]    req_in_byteen;
  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_in_addr;
  logic [NUM_REQS*DATA_WIDTH-1:0]   req_in_data;
  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_in_tag;
  logic [NUM_REQS-1:0]              req_in_ready;

  logic                     req_out_valid;
  logic                     req_out_rw;
  logic [DATA_SIZE-1:0]     req_out_byteen;
  logic [ADDR_WIDTH-1:0]    req_out_addr;
  logic [DATA_WIDTH-1:0]    req_out_data;
  logic [TAG_OUT_WIDTH-1:0] req_out_tag;
  logic                     req_out_ready;

  modport master (
    output req_in_valid, req_in_rw, req_in_byteen, req_in_addr, req_in_data, req_in_tag,
    input  req_in_ready,
    input  req_out_valid, req_out_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag,
    output req_out_ready
  );

  modport slave (
    input  req_in_valid, req_in_rw, req_in_byteen, req_in_addr, req_in_data, req_in_tag,
    output req_in_ready,
    output req_out_valid, req_out_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag,
    input  req_out_ready
  );
endinterface

// File: rtl/vx_cache_req_arb.sv
// Round-robin N:1 cache request arbiter; tags carry the winning lane index, 1-cycle latency via 2-entry buffer.
// Lane ready depends only on lane valids and buffer occupancy; VX_CACHE_ARB_PERF_EN adds perf counters.

module vx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module vx_cache_req_arb #(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int DATA_SIZE     = DATA_WIDTH / 8,
  parameter int LOG_NUM_REQS  = $clog2(NUM_REQS),
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
  input  logic clk,
  input  logic reset,
  vx_cache_req_arb_if.slave bus
`ifdef VX_CACHE_ARB_PERF_EN
  ,
  output logic [31:0] perf_req_count,
  output logic [31:0] perf_stall_count
`endif
);
  if (NUM_REQS < 2) begin : g_param_check
    $error("vx_cache_req_arb: NUM_REQS must be >= 2");
  end

  typedef struct packed {
    logic                     rw;
    logic [DATA_SIZE-1:0]     byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } entry_t;

  logic [LOG_NUM_REQS-1:0] rr_ptr;
  logic [LOG_NUM_REQS-1:0] grant_idx;
  logic                    grant_vld;
  logic [NUM_REQS-1:0]     grant;
  logic                    accept;
  logic                    pop;
  logic                    buf_empty;
  logic                    buf_full;
  entry_t                  push_entry;
  entry_t                  head;

  function automatic logic [LOG_NUM_REQS-1:0] wrap_add(input logic [LOG_NUM_REQS-1:0] base,
                                                       input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQS) sum = sum - NUM_REQS;
    return LOG_NUM_REQS'(sum);
  endfunction

  // First valid lane at or after rr_ptr, wrapping; the pointer is the top-priority lane.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQS; off++) begin
      if (!grant_vld && bus.req_in_valid[wrap_add(rr_ptr, off)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_add(rr_ptr, off);
      end
    end
  end

  assign grant            = grant_vld ? (NUM_REQS'(1) << grant_idx) : '0;
  assign bus.req_in_ready = grant & {NUM_REQS{!buf_full && !reset}};
  assign accept           = grant_vld && !buf_full && !reset;

  always_comb begin
    push_entry        = '0;
    push_entry.rw     = bus.req_in_rw[grant_idx];
    push_entry.byteen = bus.req_in_byteen[grant_idx * DATA_SIZE +: DATA_SIZE];
    push_entry.addr   = bus.req_in_addr[grant_idx * ADDR_WIDTH +: ADDR_WIDTH];
    push_entry.data   = bus.req_in_data[grant_idx * DATA_WIDTH +: DATA_WIDTH];
    push_entry.tag    = {bus.req_in_tag[grant_idx * TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign pop = bus.req_out_valid && bus.req_out_ready;

  // Full-only ready keeps req_out_ready off the input ready path.
  vx_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (2)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .empty    (buf_empty),
    .full     (buf_full)
  );

  assign bus.req_out_valid  = !buf_empty;
  assign bus.req_out_rw     = head.rw;
  assign bus.req_out_byteen = head.byteen;
  assign bus.req_out_addr   = head.addr;
  assign bus.req_out_data   = head.data;
  assign bus.req_out_tag    = head.tag;

`ifdef VX_CACHE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_count   <= '0;
      perf_stall_count <= '0;
    end else begin
      if (accept && perf_req_count != 32'hFFFF_FFFF) begin
        perf_req_count <= perf_req_count + 32'd1;
      end
      if (bus.req_out_valid && !bus.req_out_ready && perf_stall_count != 32'hFFFF_FFFF) begin
        perf_stall_count <= perf_stall_count + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_vx_cache_req_arb.sv
// Bench for vx_cache_req_arb: directed scenarios plus random traffic against a queue-based model.
module tb_vx_cache_req_arb;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TW  = 8;
  localparam int DS  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_cache_req_arb_if #(.NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)) arb_if ();

`ifdef VX_CACHE_ARB_PERF_EN
  logic [31:0] perf_req_count;
  logic [31:0] perf_stall_count;
`endif

  vx_cache_req_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (arb_if)
`ifdef VX_CACHE_ARB_PERF_EN
    ,
    .perf_req_count   (perf_req_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  typedef struct {
    logic        rw;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    logic [9:0]  tag;
  } exp_t;

  // lane-side request registers
  logic        lv    [N];
  logic        lrw   [N];
  logic [3:0]  lbe   [N];
  logic [31:0] laddr [N];
  logic [31:0] ldata [N];
  logic [7:0]  ltag  [N];
  logic        out_rdy;
  bit          refill;

  // reference model state
  exp_t q[$];
  int   ptr;
  bit   known;
  int   m_req;
  int   m_stall;

  int n_chk;
  int n_err;

  // observations from the latest step
  logic [N-1:0] obs_rdy;
  logic         obs_valid;
  logic [31:0]  obs_addr;
  logic [9:0]   obs_tag;
  int           obs_lane;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic new_payload(input int k);
    lrw[k]   = 1'($urandom_range(0, 1));
    lbe[k]   = 4'($urandom);
    laddr[k] = $urandom;
    ldata[k] = $urandom;
    ltag[k]  = 8'($urandom);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      arb_if.req_in_valid[k]            = lv[k];
      arb_if.req_in_rw[k]               = lrw[k];
      arb_if.req_in_byteen[k*DS +: DS]  = lbe[k];
      arb_if.req_in_addr[k*AW +: AW]    = laddr[k];
      arb_if.req_in_data[k*DW +: DW]    = ldata[k];
      arb_if.req_in_tag[k*TW +: TW]     = ltag[k];
    end
    arb_if.req_out_ready = out_rdy;
  endtask

  function automatic int model_grant();
    for (int o = 0; o < N; o++) begin
      if (lv[(ptr + o) % N]) return (ptr + o) % N;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check, model the edge, return at next negedge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           g;
    int           acc;
    bit           popped;
    exp_t         h;
    exp_t         e;
    drive();
    #1;
    g       = model_grant();
    exp_rdy = '0;
    if (!reset && g >= 0 && q.size() < 2) exp_rdy[g] = 1'b1;
    obs_rdy   = arb_if.req_in_ready;
    obs_valid = arb_if.req_out_valid;
    obs_addr  = arb_if.req_out_addr;
    obs_tag   = arb_if.req_out_tag;
    obs_lane  = (arb_if.req_out_valid && out_rdy) ? int'(arb_if.req_out_tag[1:0]) : -1;
    check("in_ready", arb_if.req_in_ready, exp_rdy);
    if (known) begin
      check("out_valid", arb_if.req_out_valid, q.size() != 0);
      if (q.size() != 0) begin
        h = q[0];
        check("out_rw",     arb_if.req_out_rw,     h.rw);
        check("out_byteen", arb_if.req_out_byteen, h.be);
        check("out_addr",   arb_if.req_out_addr,   h.addr);
        check("out_data",   arb_if.req_out_data,   h.data);
        check("out_tag",    arb_if.req_out_tag,    h.tag);
      end
`ifdef VX_CACHE_ARB_PERF_EN
      check("perf_req",   perf_req_count,   m_req);
      check("perf_stall", perf_stall_count, m_stall);
`endif
    end
    acc    = (exp_rdy != 0) ? g : -1;
    popped = (q.size() != 0) && out_rdy;
    @(posedge clk);
    if (reset) begin
      q.delete();
      ptr     = 0;
      m_req   = 0;
      m_stall = 0;
      known   = 1'b1;
    end else begin
      if (q.size() != 0 && !out_rdy) m_stall++;
      if (popped) void'(q.pop_front());
      if (acc >= 0) begin
        e.rw   = lrw[acc];
        e.be   = lbe[acc];
        e.addr = laddr[acc];
        e.data = ldata[acc];
        e.tag  = (10'(ltag[acc]) << 2) | 10'(acc);
        q.push_back(e);
        ptr = (acc + 1) % N;
        m_req++;
        if (refill) new_payload(acc);
        else lv[acc] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic lanes_off();
    for (int k = 0; k < N; k++) lv[k] = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    known   = 1'b0;
    ptr     = 0;
    m_req   = 0;
    m_stall = 0;
    refill  = 1'b0;
    out_rdy = 1'b1;
    reset   = 1'b1;
    for (int k = 0; k < N; k++) begin
      lv[k] = 1'b1;
      new_payload(k);
    end
    drive();
    @(negedge clk);

    // reset held two cycles with every lane requesting
    step();
    step();
    check("rst_valid",  arb_if.req_out_valid, 1'b0);
    check("rst_addr",   arb_if.req_out_addr,  32'h0);
    check("rst_data",   arb_if.req_out_data,  32'h0);
    check("rst_tag",    arb_if.req_out_tag,   10'h0);
    check("rst_ready",  arb_if.req_in_ready,  4'b0000);
    reset = 1'b0;
    step();
    check("first_grant", obs_rdy, 4'b0001);

    // single lane
    do_reset();
    lanes_off();
    lv[2] = 1'b1;
    new_payload(2);
    laddr[2] = 32'h100;
    ltag[2]  = 8'h5A;
    step();
    check("single_grant", obs_rdy, 4'b0100);
    step();
    check("single_valid", obs_valid, 1'b1);
    check("single_addr",  obs_addr,  32'h100);
    check("single_tag",   obs_tag,   10'h16A);

    // rotation with all lanes continuously valid
    do_reset();
    refill = 1'b1;
    for (int k = 0; k < N; k++) begin
      lv[k] = 1'b1;
      new_payload(k);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      check("rotate_lane", obs_lane, i % N);
    end
    refill = 1'b0;
    lanes_off();

    // backpressure with lanes 1 and 3
    do_reset();
    lv[1] = 1'b1; new_payload(1);
    lv[3] = 1'b1; new_payload(3);
    out_rdy = 1'b0;
    step();
    check("bp_grant1", obs_rdy, 4'b0010);
    step();
    check("bp_grant3", obs_rdy, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      lv[0] = 1'b1;
      step();
      check("bp_full_rdy", obs_rdy, 4'b0000);
      check("bp_hold_tag", obs_tag, (10'(ltag[1]) << 2) | 10'd1);
    end
    lanes_off();
    out_rdy = 1'b1;
    step();
    check("bp_out1", obs_lane, 1);
    step();
    check("bp_out3", obs_lane, 3);
    step();
    check("bp_empty", obs_valid, 1'b0);

    // wrap and skip: pointer at 3 with lanes 0 and 3 requesting
    do_reset();
    lv[2] = 1'b1; new_payload(2);
    step();
    lv[0] = 1'b1; new_payload(0);
    lv[3] = 1'b1; new_payload(3);
    step();
    check("wrap_grant3", obs_rdy, 4'b1000);
    step();
    check("wrap_grant0", obs_rdy, 4'b0001);
    step();

`ifdef VX_CACHE_ARB_PERF_EN
    do_reset();
    lanes_off();
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lv[0] = 1'b1;
      new_payload(0);
      step();
    end
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_rdy = 1'b1;
    step();
    check("perf_req5",   perf_req_count,   32'd5);
    check("perf_stall3", perf_stall_count, 32'd3);
    do_reset();
    check("perf_req_clr",   perf_req_count,   32'd0);
    check("perf_stall_clr", perf_stall_count, 32'd0);
`endif

    // random traffic with occasional mid-operation resets
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!lv[k] && ($urandom % 2 == 0)) begin
          lv[k] = 1'b1;
          new_payload(k);
        end
      end
      out_rdy = ($urandom % 4) != 0;
      reset   = ($urandom % 100) == 0;
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vx_cache_req_arb.md
Name: vx_cache_req_arb

Overview:
- N-to-1 round-robin arbiter for cache request lanes.
- Merges NUM_REQS request lanes (core/LSU side) onto one cache/memory request port.
- Appends the winning lane index to the request tag so the response path can route responses back.
- Output is registered through a 2-entry elastic buffer. There is no combinational path from req_out_ready to req_in_ready.

Parameters:
- NUM_REQS, 4, number of input request lanes; must be >= 2 (elaboration error otherwise).
- DATA_WIDTH, 32, request data width in bits.
- ADDR_WIDTH, 32, request address width.
- TAG_IN_WIDTH, 8, per-lane input tag width.
- DATA_SIZE, DATA_WIDTH/8, byte-enable width.
- LOG_NUM_REQS, $clog2(NUM_REQS), lane index width (derived).
- TAG_OUT_WIDTH, TAG_IN_WIDTH+LOG_NUM_REQS, output tag width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_in_valid  in  NUM_REQS  per-lane request valid
- req_in_rw  in  NUM_REQS  per-lane write(1)/read(0)
- req_in_byteen  in  NUM_REQS*DATA_SIZE  per-lane byte enables
- req_in_addr  in  NUM_REQS*ADDR_WIDTH  per-lane address
- req_in_data  in  NUM_REQS*DATA_WIDTH  per-lane write data
- req_in_tag  in  NUM_REQS*TAG_IN_WIDTH  per-lane tag
- req_in_ready  out  NUM_REQS  per-lane accept
- req_out_valid  out  1  merged request valid
- req_out_rw  out  1  merged rw
- req_out_byteen  out  DATA_SIZE  merged byte enables
- req_out_addr  out  ADDR_WIDTH  merged address
- req_out_data  out  DATA_WIDTH  merged data
- req_out_tag  out  TAG_OUT_WIDTH  {lane tag, lane index}
- req_out_ready  in  1  downstream accept

Behaviour:
- Clock/reset: single clock domain (clk). reset is synchronous and active-high. Reset applies at the next clk edge.
- Reset state:
  - buffer count=0, so req_out_valid=0.
  - round-robin pointer rr_ptr=0 (lane 0 highest priority).
  - req_out payload outputs=0.
  - perf counters=0.
- Arbitration (combinational, each cycle):
  - grant = first valid lane scanning from rr_ptr upward, with wrap-around mod NUM_REQS.
  - At most one grant bit is set.
- Ready rule:
  - req_in_ready[i] = grant[i] && (count<2).
  - Non-granted lanes always see ready=0.
  - ready depends only on req_in_valid and registered state.
- Accept: a handshake on lane k (valid&&ready) at edge t has these effects:
  - Pushes {rw, byteen, addr, data, tag_k, k} into the buffer.
  - The lane index k occupies the LSBs of req_out_tag; tag_k occupies the upper TAG_IN_WIDTH bits.
  - Sets rr_ptr <= (k+1) mod NUM_REQS. On k=NUM_REQS-1 it wraps to 0.
- No accept: rr_ptr holds.
- Latency: request accepted at edge t appears on req_out at cycle t+1 when the buffer was empty.
- Output:
  - req_out_valid = (count!=0); payload = head entry.
  - Pop on req_out_valid && req_out_ready.
  - Payload and valid must stay stable while valid && !ready.
- Buffer boundaries:
  - count 0: no pop possible; push allowed.
  - count 1: push and pop in the same cycle leaves count=1. This sustains 1 request/cycle.
  - count 2 (full): all req_in_ready=0, pop allowed, count->1.
- Input stability: a lane whose valid is high but not granted must hold its payload. The arbiter never drops a request.
- Fairness: with all lanes continuously valid and downstream always ready, grants rotate 0,1,..,N-1,0. Each lane is served once per N accepted requests.
- Reset mid-operation: buffered entries are discarded, count=0, rr_ptr=0. req_in_ready=0 during the reset cycle.

Optional Feature:
- Macro: VX_CACHE_ARB_PERF_EN.
- When defined, adds these output ports:
  - perf_req_count, 32 bits: accepted requests.
  - perf_stall_count, 32 bits: cycles with req_out_valid && !req_out_ready.
- Counters saturate at 2^32-1 and clear on reset.
- When undefined, the ports and logic are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset: assert reset 2 cycles with all lanes valid -> req_in_ready=0 and req_out_valid=0 throughout; after release, first grant goes to lane 0.
- Single lane: lane 2 only, addr=0x100, tag=0x5A, NUM_REQS=4 -> req_out_valid next cycle, addr=0x100, req_out_tag=0x5A<<2|2=0x16A.
- Rotation: all 4 lanes valid, req_out_ready=1 for 8 cycles -> output lane order 0,1,2,3,0,1,2,3; one output per cycle after 1-cycle latency.
- Backpressure: req_out_ready=0 with lanes 1,3 valid -> 2 accepts (lane 1, then lane 3), then all ready=0; payload held stable. Raise ready -> lane 1 then lane 3 emitted, no loss or duplication.
- Wrap/skip: rr_ptr=3 with only lanes 0 and 3 valid -> lane 3 granted, rr_ptr=0, then lane 0.
- Perf (macro on): 5 accepts, downstream stalled 3 cycles -> perf_req_count=5, perf_stall_count=3; reset clears both to 0.
